// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register file write port arbiter: WB priority, buffered long-latency results
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic [31:0] busy_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_STEAL} state_t;

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic wb_act, empty, full, push, store, pop;

    assign wb_act    = wb_we && (wb_waddr != 5'd0);
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // Ready looks only at registered occupancy, never at the same-cycle pop
    assign lu_ready  = resetn && !full;
    assign push      = lu_valid && lu_ready;
    assign store     = push && (lu_waddr != 5'd0);
    assign pop       = !wb_act && !empty;
    assign count_nxt = count + CW'(store) - CW'(pop);
    assign stall_req = (state == S_STEAL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= S_IDLE;
            cnt    <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[wr_ptr] <= lu_waddr;
            data_q[wr_ptr] <= lu_wdata;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (resetn) begin
            if (wb_act) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = addr_q[rd_ptr];
                rf_wdata = data_q[rd_ptr];
            end
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) busy_mask[addr_q[idx]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (store) state_nxt = S_PEND;
            end
            S_PEND: begin
                if (pop) begin
                    cnt_nxt = '0;
                    if (count_nxt == '0) state_nxt = S_IDLE;
                end else if (wb_act) begin
                    if (int'(cnt) + 1 >= STARVE_LIMIT) begin
                        state_nxt = S_STEAL;
                        cnt_nxt   = 4'(STARVE_LIMIT);
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            S_STEAL: begin
                // A WB write here breaks the bubble contract; WB still wins and we keep asking
                if (pop) begin
                    cnt_nxt   = '0;
                    state_nxt = (count_nxt == '0) ? S_IDLE : S_PEND;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Arbitrates the register file's single write port between the in-order writeback stage and a long-latency result source, such as the divider or a miss-returning load unit. Writeback results always win and are written with zero added latency. Long-latency results are accepted through a valid/ready handshake, held in a small in-order buffer, and drained into idle write slots. A starvation counter requests a pipeline bubble when buffered results are blocked too long. The block sits between the WB stage, the long-latency unit, and the register file write port, and exports a pending-destination mask to the hazard unit.

## Interface
- DEPTH, 2, buffer entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive blocked drain cycles before a bubble is requested; 1..15

- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- wb_we  in  1  WB stage write request
- wb_waddr  in  5  WB destination register
- wb_wdata  in  32  WB data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  buffer can accept a result
- lu_waddr  in  5  long-latency destination register
- lu_wdata  in  32  long-latency data
- rf_we  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- stall_req  out  1  request: pipeline must present wb_we=0 in this cycle's following slot
- busy_mask  out  32  bit r = 1 iff a buffered write to xr is pending

## Operation
- Effective WB request: wb_act = wb_we && wb_waddr != 0. A write to x0 is treated as idle.
- Port mux, evaluated each cycle:
  - If wb_act: rf_* = wb_*.
  - Else if the buffer is non-empty: rf_* = head entry, and the head is popped at the next edge.
  - Else: rf_we = 0, rf_waddr = 0, rf_wdata = 0.
- Push: at an edge with lu_valid && lu_ready. If lu_waddr = 0, the result is accepted and discarded, nothing is stored.
- lu_ready = !full. It depends only on registered count and not on a same-cycle pop, so there is no combinational path from wb_we to lu_ready.
- Simultaneous push and pop: occupancy is unchanged and order is preserved (FIFO, circular pointers wrap at DEPTH).
- busy_mask: the OR of one-hot(waddr) over all valid entries, decoded from registered state. Bit 0 is always 0.
- No reordering or WAW resolution. The hazard unit uses busy_mask to block issue of instructions whose rd or rs is pending.
- Starvation FSM with a saturating counter cnt:
  - IDLE: buffer empty, cnt = 0. Goes to PEND on any push.
  - PEND: each edge where the buffer is non-empty and wb_act blocks the drain does cnt += 1. Any pop sets cnt = 0. If cnt would reach STARVE_LIMIT, go to STEAL. If the buffer becomes empty, go to IDLE.
  - STEAL: stall_req = 1. On a pop, cnt = 0 and the FSM goes to PEND, or to IDLE if the buffer is now empty. If wb_act is still asserted (a protocol violation), WB still wins with no data loss, and the FSM stays in STEAL.
- Reset (async, at any time) gives:
  - buffer flushed and pointers 0
  - cnt = 0, FSM in IDLE
  - lu_ready = 0 while resetn is low, 1 after release
  - rf_we forced 0 while resetn is low
  - stall_req = 0, busy_mask = 0
  - In-flight buffered results are lost.

## Timing
- WB path is purely combinational, with 0 cycles added. The register file captures at the same edge the WB stage presents the write.
- Long-latency path, minimum latency:
  - Handshake at edge k.
  - Entry is visible and rf_we is asserted in cycle k..k+1.
  - Register file write occurs at edge k+1.
  - busy_mask bit sets at edge k and clears at the pop edge.
- stall_req is registered. With STARVE_LIMIT = 4, four consecutive blocked edges raise stall_req in the following cycle. It drops at the edge the head pops.
- Drain throughput: one entry per cycle in which wb_act = 0.
- A full buffer with a pop and lu_valid in the same cycle: lu_ready = 0, so no push occurs. The push is accepted the next cycle.

## Test plan
- Idle WB, push x5 = 0x1234 at edge k -> rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234 during the following cycle; busy_mask = 0x20 for exactly one cycle; stall_req stays 0.
- wb_we = 1 to x3 = 0xAA while pushing x7 = 0xBB -> x3 is written first; x7 drains in the first cycle with wb_act = 0; the order of two buffered pushes (x7, then x9) is preserved.
- DEPTH = 2: push twice with WB busy -> lu_ready = 0 and busy_mask has two bits set; a third lu_valid is held until after the first pop; no entry is lost or duplicated.
- WB busy continuously with one buffered entry, STARVE_LIMIT = 4 -> stall_req = 1 after 4 blocked edges; the bench drops wb_we -> entry drains and stall_req = 0 the next cycle.
- Push to x0, and wb_we = 1 with wb_waddr = 0 -> nothing is stored, rf_we = 0 for x0, and a pending entry drains in the x0-WB cycle.
- Assert resetn = 0 mid-drain with 2 entries buffered -> rf_we, stall_req, busy_mask, lu_ready go to 0 immediately without a clock edge; after release the buffer is empty and the first push drains normally.
